cd_sram_arbiter: RTL
====================

Name: cd_sram_arbiter

Overview:
Single-port scheduler for the Color/Depth SRAM. It shares the SRAM between three users: the Rasterization write/read path, a display readout requester, and an internal frame-clear engine. The clear engine initialises every word to the background colour and maximum depth before a frame. The block sits between Rasterization and the top-level SRAM_CD pins, and it owns address_sram_CD, write enable, wordmask and write data.

Parameters:
ADDR_W, 16, SRAM word address width; the SRAM holds 2**ADDR_W words.
MAX_RD_STREAK, 4, maximum consecutive readout grants while raster is requesting.

Ports:
clk  in  1  clock
srst_n  in  1  reset, asynchronous, active-low
clear_start  in  1  one-cycle pulse that starts a frame clear
clear_color  in  24  RGB background colour, replicated into all 16 pixels
clear_busy  out  1  high while the clear sweep runs
clear_done  out  1  one-cycle pulse when the sweep completes
ras_req  in  1  raster access request
ras_we  in  1  raster access type: 1 write, 0 read
ras_addr  in  ADDR_W  raster word address
ras_color  in  384  raster colour write data (16 px x 24b)
ras_depth  in  336  raster depth write data (16 px x 21b)
ras_mask  in  16  raster per-pixel write mask
ras_gnt  out  1  raster request accepted this cycle
ras_rvalid  out  1  rdata_* holds raster read data
rd_req  in  1  readout read request
rd_addr  in  ADDR_W  readout word address
rd_gnt  out  1  readout request accepted this cycle
rd_rvalid  out  1  rdata_* holds readout data
rdata_color  out  384  returned colour word
rdata_depth  out  336  returned depth word
sram_addr  out  ADDR_W  SRAM address (registered)
sram_we  out  1  SRAM write enable (registered)
sram_mask  out  16  SRAM wordmask (registered)
sram_wcolor  out  384  SRAM colour write data (registered)
sram_wdepth  out  336  SRAM depth write data (registered)
sram_rcolor  in  384  SRAM colour read data, valid 1 cycle after address
sram_rdepth  in  336  SRAM depth read data, valid 1 cycle after address

Behaviour:
- Reset: all outputs and registers 0, including clear_busy, gnts, rvalids and sram_*. Clear counter 0, rd_streak 0. Reset asserted mid-sweep or mid-read aborts it; no rvalid or clear_done is emitted for it afterwards.
- Grants are combinational in the request cycle. The granted access drives sram_* on the next clock edge.
- Requesters hold req/addr/data stable until their gnt is seen.
- Read data latency from gnt to rvalid is exactly 2 cycles. A 2-deep shift register carries {valid, owner}. rdata_* register sram_r* and are meaningful only while an rvalid is high.
- Idle cycle (no grant): sram_we=0, sram_mask=0; sram_addr holds its last value.
- Clear engine:
  - clear_start with clear_busy=0: clear_busy goes high next cycle and the counter starts at 0.
  - Each busy cycle issues one write: addr=counter, mask=16'hFFFF, wcolor = clear_color (latched at start) x16, wdepth = 21'h1FFFFF x16. Counter then increments.
  - After the write to address 2**ADDR_W-1: clear_busy drops and clear_done pulses in the same cycle the last write appears on sram_*. Counter wraps to 0.
  - clear_start while busy is ignored.
  - While busy, ras_gnt=rd_gnt=0.
  - Reads granted before the sweep started still complete their rvalid.
- Arbitration, when not clearing:
  - Only one requester: it is granted.
  - Both requesting: readout wins unless rd_streak==MAX_RD_STREAK, in which case raster wins.
  - rd_streak increments on each rd grant while ras_req is high. It clears on a raster grant, and also on a cycle where ras_req is low.
  - Same-cycle clear_start and requests: the requests are granted this cycle, and the clear begins the following cycle.
- The write path passes ras_mask unchanged. Readout is read-only.
- A raster read and write to the same address in back-to-back grants are ordered by grant order; no forwarding is done.

Decomposition:
- Shared package: ADDR_W default, PIX_PER_WORD=16, COLOR_W=24, DEPTH_W=21, DEPTH_MAX=21'h1FFFFF, and owner-tag encodings (OWN_RAS=0, OWN_RD=1).
- One natural sub-module, cd_clear_sweeper. It owns the counter, the latched colour and busy/done, and emits a write request with forced top priority.
- The arbiter and the read-return pipeline stay in the top module.

Test Plan:
- Reset, then clear_start with clear_color=24'h102030 and ADDR_W=4: 16 consecutive writes, addr 0..15, mask FFFF, wcolor={16{24'h102030}}, wdepth all 1s. clear_done pulses with the addr-15 write. clear_busy is high for 16 cycles.
- ras_req write at addr 5, mask 16'h00F0 alone: ras_gnt same cycle; next cycle sram_we=1, sram_addr=5, sram_mask=00F0.
- ras and rd read requests held continuously (MAX_RD_STREAK=4): grant pattern rd,rd,rd,rd,ras,rd,rd,rd,rd,ras. Each rvalid arrives 2 cycles after its gnt with the correct owner flag.
- rd read at addr 9 with the SRAM model returning a known word: rd_rvalid exactly 2 cycles after rd_gnt; rdata_color and rdata_depth equal the model's data.
- Requests held during a clear sweep: zero grants until clear_busy falls; the first grant occurs in the cycle after the final clear write.
- srst_n pulled low at clear counter=7: all outputs go to 0 immediately. After release, no clear_done and no write until a new clear_start.

Source files
------------

// File: rtl/cd_sram_arbiter_pkg.sv
// Shared widths, owner tags and helpers for the Color/Depth SRAM scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cd_sram_arbiter_pkg;

    localparam int ADDR_W_DEF        = 16;
    localparam int MAX_RD_STREAK_DEF = 4;
    localparam int PIX_PER_WORD      = 16;
    localparam int COLOR_W           = 24;
    localparam int DEPTH_W           = 21;
    localparam int WCOLOR_W          = PIX_PER_WORD * COLOR_W;   // 384
    localparam int WDEPTH_W          = PIX_PER_WORD * DEPTH_W;   // 336

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = 21'h1FFFFF;

    // Who a read-return belongs to as it travels down the return pipe
    typedef enum logic {
        OWN_RAS = 1'b0,
        OWN_RD  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e own;
    } rd_tag_t;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_BUSY = 1'b1
    } clr_state_e;

    // One background colour spread across every pixel of a word
    function automatic logic [WCOLOR_W-1:0] rep_color(input logic [COLOR_W-1:0] c);
        return {PIX_PER_WORD{c}};
    endfunction

endpackage

// File: rtl/cd_clear_sweeper.sv
// Frame-clear engine: walks every SRAM word once, one write per busy cycle.
// Latency: busy rises the cycle after start; done pulses one cycle after the last issued write.
// Backpressure: none; its write request has absolute priority at the arbiter.
module cd_clear_sweeper
    import cd_sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic               clk,
    input  logic               srst_n,
    input  logic               i_start,
    input  logic [COLOR_W-1:0] i_color,
    output logic               o_busy,
    output logic               o_done,
    output logic [ADDR_W-1:0]  o_addr,
    output logic [COLOR_W-1:0] o_color
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_e          r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
    logic [COLOR_W-1:0]  r_color, w_color_nxt;
    logic                r_done, w_done_nxt;

    // State, counter, latched colour and done pulse registers
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_state <= CLR_IDLE;
            r_cnt   <= '0;
            r_color <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_color <= w_color_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Start only from idle (start while busy is dropped); stop after the top address
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_color_nxt = r_color;
        w_done_nxt  = 1'b0;
        case (r_state)
            CLR_IDLE: begin
                if (i_start) begin
                    w_state_nxt = CLR_BUSY;
                    w_cnt_nxt   = '0;
                    w_color_nxt = i_color;
                end
            end
            CLR_BUSY: begin
                w_cnt_nxt = r_cnt + ADDR_W'(1);
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = CLR_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = CLR_IDLE;
        endcase
    end

    assign o_busy  = (r_state == CLR_BUSY);
    assign o_done  = r_done;
    assign o_addr  = r_cnt;
    assign o_color = r_color;

endmodule

// File: rtl/cd_sram_arbiter.sv
// Single-port Color/Depth SRAM scheduler: clear sweep > readout/raster (readout favoured, streak-limited).
// Latency: grant combinational in request cycle, SRAM pins next edge, read data/rvalid 2 cycles after grant.
// Backpressure: requesters hold req until gnt; both gnts forced low while the clear sweep is busy.
module cd_sram_arbiter
    import cd_sram_arbiter_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int MAX_RD_STREAK = MAX_RD_STREAK_DEF
)(
    input  logic                clk,
    input  logic                srst_n,
    input  logic                clear_start,
    input  logic [COLOR_W-1:0]  clear_color,
    output logic                clear_busy,
    output logic                clear_done,
    input  logic                ras_req,
    input  logic                ras_we,
    input  logic [ADDR_W-1:0]   ras_addr,
    input  logic [WCOLOR_W-1:0] ras_color,
    input  logic [WDEPTH_W-1:0] ras_depth,
    input  logic [15:0]         ras_mask,
    output logic                ras_gnt,
    output logic                ras_rvalid,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_gnt,
    output logic                rd_rvalid,
    output logic [WCOLOR_W-1:0] rdata_color,
    output logic [WDEPTH_W-1:0] rdata_depth,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_we,
    output logic [15:0]         sram_mask,
    output logic [WCOLOR_W-1:0] sram_wcolor,
    output logic [WDEPTH_W-1:0] sram_wdepth,
    input  logic [WCOLOR_W-1:0] sram_rcolor,
    input  logic [WDEPTH_W-1:0] sram_rdepth
);

    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);

    logic                 w_clr_busy;
    logic [ADDR_W-1:0]    w_clr_addr;
    logic [COLOR_W-1:0]   w_clr_color;
    logic                 w_rd_max;
    logic                 w_ras_gnt;
    logic                 w_rd_gnt;
    rd_tag_t              w_tag;
    rd_tag_t              r_tag1, r_tag2;
    logic [STREAK_W-1:0]  r_rd_streak;
    logic [ADDR_W-1:0]    r_sram_addr;
    logic                 r_sram_we;
    logic [15:0]          r_sram_mask;
    logic [WCOLOR_W-1:0]  r_sram_wcolor;
    logic [WDEPTH_W-1:0]  r_sram_wdepth;
    logic [WCOLOR_W-1:0]  r_rcolor;
    logic [WDEPTH_W-1:0]  r_rdepth;

    cd_clear_sweeper #(
        .ADDR_W (ADDR_W)
    ) u_sweeper (
        .clk     (clk),
        .srst_n  (srst_n),
        .i_start (clear_start),
        .i_color (clear_color),
        .o_busy  (w_clr_busy),
        .o_done  (clear_done),
        .o_addr  (w_clr_addr),
        .o_color (w_clr_color)
    );

    // Readout wins a tie unless it has already taken MAX_RD_STREAK grants over a waiting raster
    assign w_rd_max  = (r_rd_streak == STREAK_W'(MAX_RD_STREAK));
    assign w_rd_gnt  = !w_clr_busy && rd_req && !(ras_req && w_rd_max);
    assign w_ras_gnt = !w_clr_busy && ras_req && !w_rd_gnt;

    // Tag entering the return pipe this cycle
    always_comb begin
        w_tag     = '0;
        w_tag.vld = (w_ras_gnt && !ras_we) || w_rd_gnt;
        w_tag.own = w_rd_gnt ? OWN_RD : OWN_RAS;
    end

    // Count readout grants that starve a waiting raster; forget as soon as raster is served or idle
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_rd_streak <= '0;
        end else if (!ras_req || w_ras_gnt) begin
            r_rd_streak <= '0;
        end else if (w_rd_gnt) begin
            r_rd_streak <= r_rd_streak + STREAK_W'(1);
        end
    end

    // Drive the SRAM pins from the winning access; idle cycles keep the address and write nothing
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_sram_addr   <= '0;
            r_sram_we     <= 1'b0;
            r_sram_mask   <= '0;
            r_sram_wcolor <= '0;
            r_sram_wdepth <= '0;
        end else if (w_clr_busy) begin
            r_sram_addr   <= w_clr_addr;
            r_sram_we     <= 1'b1;
            r_sram_mask   <= '1;
            r_sram_wcolor <= rep_color(w_clr_color);
            r_sram_wdepth <= {PIX_PER_WORD{DEPTH_MAX}};
        end else if (w_ras_gnt) begin
            r_sram_addr   <= ras_addr;
            r_sram_we     <= ras_we;
            r_sram_mask   <= ras_we ? ras_mask : 16'h0000;
            r_sram_wcolor <= ras_color;
            r_sram_wdepth <= ras_depth;
        end else if (w_rd_gnt) begin
            r_sram_addr   <= rd_addr;
            r_sram_we     <= 1'b0;
            r_sram_mask   <= '0;
        end else begin
            r_sram_we     <= 1'b0;
            r_sram_mask   <= '0;
        end
    end

    // Two-stage {valid, owner} pipe; data is captured from the SRAM while stage 1 is valid
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_tag1   <= '0;
            r_tag2   <= '0;
            r_rcolor <= '0;
            r_rdepth <= '0;
        end else begin
            r_tag1 <= w_tag;
            r_tag2 <= r_tag1;
            if (r_tag1.vld) begin
                r_rcolor <= sram_rcolor;
                r_rdepth <= sram_rdepth;
            end
        end
    end

    assign clear_busy  = w_clr_busy;
    assign ras_gnt     = w_ras_gnt;
    assign rd_gnt      = w_rd_gnt;
    assign ras_rvalid  = r_tag2.vld && (r_tag2.own == OWN_RAS);
    assign rd_rvalid   = r_tag2.vld && (r_tag2.own == OWN_RD);
    assign rdata_color = r_rcolor;
    assign rdata_depth = r_rdepth;
    assign sram_addr   = r_sram_addr;
    assign sram_we     = r_sram_we;
    assign sram_mask   = r_sram_mask;
    assign sram_wcolor = r_sram_wcolor;
    assign sram_wdepth = r_sram_wdepth;

endmodule
